rr_bus_arbiter_4_1: RTL and testbench
=====================================

Name: rr_bus_arbiter_4_1

Overview:
- Four-requester round-robin arbiter with a registered output stage.
- Sits directly upstream of the team's 8-bit 4:1 bus mux datapath. It generates the 2-bit select, captures the winning bus word and presents it downstream.
- Uses a valid/ready handshake on all four inputs and on the output.
- Throughput is one word per cycle, with 1-cycle latency from input handshake to output valid.

Parameters:
- WIDTH, 8, bit width of each data bus (a, b, c, d and output).

Ports:
- i_clk  input  1  single clock; all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  4  per-requester valid; bit 0=a, 1=b, 2=c, 3=d
- i_a  input  WIDTH  requester 0 data
- i_b  input  WIDTH  requester 1 data
- i_c  input  WIDTH  requester 2 data
- i_d  input  WIDTH  requester 3 data
- o_ready  output  4  one-hot (or zero) accept strobe back to requesters; combinational
- o_valid  output  1  output word valid (registered)
- o_data  output  WIDTH  captured word (registered)
- o_sel  output  2  index of requester that produced o_data (registered)
- i_ready  input  1  downstream accepts o_data when o_valid && i_ready

Behaviour:
- Reset: i_rst high asynchronously forces:
  - o_valid=0, o_data=0, o_sel=2'b00.
  - Internal last-grant pointer = 3, so requester 0 has first priority.
  - o_ready is forced to 4'b0000 while i_rst is high.
- States: EMPTY (o_valid=0) and FULL (o_valid=1). The state is o_valid itself; there are no other state bits besides the last-grant pointer.
- Load enable: load = !o_valid || i_ready.
- Arbitration is combinational each cycle:
  - Search i_valid starting at (last+1) mod 4, wrapping 3->0. The first set bit is the winner g.
  - If load && |i_valid, then o_ready = 1<<g; otherwise o_ready = 0.
  - At most one o_ready bit is ever high.
- On rising edge with load=1:
  - If any i_valid: o_data <= selected input (a/b/c/d per g), o_sel <= g, o_valid <= 1, last <= g.
  - If no i_valid: o_valid <= 0. o_data, o_sel and last hold.
- On rising edge with load=0 (FULL and i_ready=0): all registers hold and o_ready=0. This is backpressure.
- Transitions:
  - EMPTY->FULL on any i_valid.
  - FULL->FULL on i_ready && any i_valid (back-to-back, 1 word/cycle).
  - FULL->EMPTY on i_ready && no i_valid.
  - FULL->FULL (hold) on !i_ready.
- Fairness:
  - A requester that loses is served within 3 subsequent grants while it keeps i_valid high.
  - A single continuously valid requester is granted every cycle; the pointer simply re-lands on it.
- Requester rules:
  - Once raised, i_valid[n] must stay high with stable data until o_ready[n]=1.
  - The arbiter does not depend on this rule for correctness of its own registers. The bench flags violations.
- Output stability: while o_valid=1 and i_ready=0, o_data and o_sel must not change.
- Reset mid-operation: the in-flight word is discarded (o_valid drops immediately, asynchronously). After release, priority restarts at requester 0.
- o_data is not zeroed on drain to EMPTY; only reset clears it.

Test Plan:
- Reset then idle: assert i_rst, release; i_valid=0 for 5 cycles -> o_valid=0, o_data=0x00, o_sel=0, o_ready=0000 throughout.
- Single requester: i_valid=0010, i_b=0x5A, i_ready=1 -> same cycle o_ready=0010; next edge o_valid=1, o_data=0x5A, o_sel=1. Drop i_valid -> o_valid=0 one cycle later.
- Round-robin rotation: i_valid=1111 held, data a=0x11, b=0x22, c=0x33, d=0x44, i_ready=1 -> o_data sequence 0x11,0x22,0x33,0x44,0x11 on consecutive cycles; o_sel 0,1,2,3,0.
- Backpressure: FULL with o_data=0x33, i_ready=0 for 4 cycles, i_valid=1001 -> o_ready=0000, o_data stays 0x33. Raise i_ready -> o_ready=1000 (pointer last=2, so d wins before a), then o_data=0x44.
- Wrap and skip: last grant=3, i_valid=0100 -> winner c. Then i_valid=1010 -> winner d; next cycle winner b.
- Async reset mid-stream: during the rotation test, pulse i_rst between clock edges -> o_valid=0 immediately. After release with i_valid=1111, first grant is a (o_sel=0).

Source files
------------

// File: rtl/rr_bus_arbiter_4_1_if.sv
// Bundle of the four requester channels and the registered downstream channel
// for the 4:1 round-robin bus arbiter.
interface rr_bus_arbiter_4_1_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       i_valid;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_c;
    logic [WIDTH-1:0] i_d;
    logic [3:0]       o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_sel;
    logic             i_ready;

    // Arbiter side
    modport master (
        input  i_valid, i_a, i_b, i_c, i_d, i_ready,
        output o_ready, o_valid, o_data, o_sel
    );

    // Requester / downstream side
    modport slave (
        output i_valid, i_a, i_b, i_c, i_d, i_ready,
        input  o_ready, o_valid, o_data, o_sel
    );
endinterface

// File: rtl/rr_bus_arbiter_4_1.sv
// Four-requester round-robin arbiter with a single registered output word.
// The output valid flag is the whole FSM; the last-grant pointer sets priority.
module rr_bus_arbiter_4_1 #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rr_bus_arbiter_4_1_if.master bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       last_reg, last_next;
    logic [1:0]       sel_reg, sel_next;
    logic [WIDTH-1:0] data_reg, data_next;

    logic [WIDTH-1:0] bus_word [4];
    logic [1:0]       cand [4];
    logic [3:0]       req_rot;
    logic [1:0]       grant_idx;
    logic             any_req;
    logic             load;

    assign bus_word[0] = bus.i_a;
    assign bus_word[1] = bus.i_b;
    assign bus_word[2] = bus.i_c;
    assign bus_word[3] = bus.i_d;

    // Candidate gi is the requester gi+1 places after the last winner; the
    // 2-bit add wraps 3->0, and the fourth candidate is the last winner itself.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign cand[gi]    = last_reg + 2'(gi + 1);
            assign req_rot[gi] = bus.i_valid[cand[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = cand[0];
        if (req_rot[0])      grant_idx = cand[0];
        else if (req_rot[1]) grant_idx = cand[1];
        else if (req_rot[2]) grant_idx = cand[2];
        else                 grant_idx = cand[3];
    end

    assign any_req = |bus.i_valid;
    assign load    = (state_reg == ST_EMPTY) || bus.i_ready;

    // Accept strobe is suppressed during reset so no requester sees a grant
    // for a word that the cleared register will never hold.
    assign bus.o_ready = (load && any_req && !i_rst) ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        sel_next   = sel_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (any_req) begin
                    state_next = ST_FULL;
                    last_next  = grant_idx;
                    sel_next   = grant_idx;
                    data_next  = bus_word[grant_idx];
                end
            end
            ST_FULL: begin
                if (bus.i_ready) begin
                    if (any_req) begin
                        last_next = grant_idx;
                        sel_next  = grant_idx;
                        data_next = bus_word[grant_idx];
                    end else begin
                        // Data and select are left as-is on drain
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_EMPTY;
            last_reg  <= 2'd3;
            sel_reg   <= 2'd0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
        end
    end

    assign bus.o_valid = (state_reg == ST_FULL);
    assign bus.o_data  = data_reg;
    assign bus.o_sel   = sel_reg;

endmodule

// File: tb/tb_rr_bus_arbiter_4_1.sv
// Directed bench for rr_bus_arbiter_4_1: reset, single requester, rotation,
// backpressure, wrap/skip and asynchronous reset in mid-stream.
module tb_rr_bus_arbiter_4_1;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;

    rr_bus_arbiter_4_1_if #(.WIDTH(WIDTH)) bus ();

    rr_bus_arbiter_4_1 #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
        chk({tag, ".data"},  32'(bus.o_data),  32'(d));
        chk({tag, ".sel"},   32'(bus.o_sel),   32'(s));
    endtask

    initial begin
        n_tests     = 0;
        n_failed    = 0;
        rst         = 1'b0;
        bus.i_valid = 4'b0000;
        bus.i_a     = 8'h00;
        bus.i_b     = 8'h00;
        bus.i_c     = 8'h00;
        bus.i_d     = 8'h00;
        bus.i_ready = 1'b0;

        // Reset: o_ready stays low even with every requester asking
        #2 rst = 1'b1;
        bus.i_valid = 4'b1111;
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset.ready", 32'(bus.o_ready), 32'h0);
        $display("[TB] reset held: o_valid=%0b o_ready=%b", bus.o_valid, bus.o_ready);
        bus.i_valid = 4'b0000;
        #2 rst = 1'b0;

        // Idle for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("idle", 1'b0, 8'h00, 2'd0);
            chk("idle.ready", 32'(bus.o_ready), 32'h0);
            $display("[TB] idle cycle %0d: o_valid=%0b o_ready=%b", i, bus.o_valid, bus.o_ready);
        end

        // Single requester b
        bus.i_ready = 1'b1;
        bus.i_valid = 4'b0010;
        bus.i_b     = 8'h5A;
        #1 chk("single.ready", 32'(bus.o_ready), 32'b0010);
        tick();
        chk_out("single.word", 1'b1, 8'h5A, 2'd1);
        $display("[TB] single: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        bus.i_valid = 4'b0000;
        tick();
        chk_out("single.drain", 1'b0, 8'h5A, 2'd1);
        $display("[TB] drain: o_valid=%0b o_data=%h", bus.o_valid, bus.o_data);

        // Restart priority at requester 0 with a reset pulse between edges
        #2 rst = 1'b1;
        #1 rst = 1'b0;

        // Round-robin rotation, then continue into backpressure at c
        bus.i_a     = 8'h11;
        bus.i_b     = 8'h22;
        bus.i_c     = 8'h33;
        bus.i_d     = 8'h44;
        bus.i_valid = 4'b1111;
        tick(); chk_out("rot0", 1'b1, 8'h11, 2'd0); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        tick(); chk_out("rot1", 1'b1, 8'h22, 2'd1); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        tick(); chk_out("rot2", 1'b1, 8'h33, 2'd2); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        tick(); chk_out("rot3", 1'b1, 8'h44, 2'd3); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        tick(); chk_out("rot4", 1'b1, 8'h11, 2'd0); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);
        tick(); chk_out("rot5", 1'b1, 8'h22, 2'd1);
        tick(); chk_out("rot6", 1'b1, 8'h33, 2'd2); $display("[TB] rot: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);

        // Backpressure: FULL with 0x33, last grant = c
        bus.i_ready = 1'b0;
        bus.i_valid = 4'b1001;
        #1 chk("bp.ready0", 32'(bus.o_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("bp.hold", 1'b1, 8'h33, 2'd2);
            chk("bp.ready", 32'(bus.o_ready), 32'h0);
            $display("[TB] backpressure %0d: o_data=%h o_ready=%b", i, bus.o_data, bus.o_ready);
        end
        bus.i_ready = 1'b1;
        #1 chk("bp.release.ready", 32'(bus.o_ready), 32'b1000);
        tick();
        chk_out("bp.release.word", 1'b1, 8'h44, 2'd3);
        chk("bp.next.ready", 32'(bus.o_ready), 32'b0001);
        tick();
        chk_out("bp.next.word", 1'b1, 8'h11, 2'd0);
        $display("[TB] after backpressure: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);

        // Wrap and skip: bring last grant to 3 first
        bus.i_valid = 4'b1000;
        tick();
        chk_out("wrap.setup", 1'b1, 8'h44, 2'd3);
        bus.i_valid = 4'b0100;
        #1 chk("wrap.c.ready", 32'(bus.o_ready), 32'b0100);
        tick();
        chk_out("wrap.c.word", 1'b1, 8'h33, 2'd2);
        bus.i_valid = 4'b1010;
        #1 chk("skip.d.ready", 32'(bus.o_ready), 32'b1000);
        tick();
        chk_out("skip.d.word", 1'b1, 8'h44, 2'd3);
        chk("skip.b.ready", 32'(bus.o_ready), 32'b0010);
        tick();
        chk_out("skip.b.word", 1'b1, 8'h22, 2'd1);
        $display("[TB] wrap/skip: o_data=%h o_sel=%0d", bus.o_data, bus.o_sel);

        // Async reset in the middle of a stream
        bus.i_valid = 4'b1111;
        tick();
        chk_out("mid.c", 1'b1, 8'h33, 2'd2);
        tick();
        chk_out("mid.d", 1'b1, 8'h44, 2'd3);
        #2 rst = 1'b1;
        #1;
        chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
        chk("mid.rst.ready", 32'(bus.o_ready), 32'h0);
        $display("[TB] mid-stream reset: o_valid=%0b o_ready=%b", bus.o_valid, bus.o_ready);
        rst = 1'b0;
        #1 chk("mid.post.ready", 32'(bus.o_ready), 32'b0001);
        tick();
        chk_out("mid.post.word", 1'b1, 8'h11, 2'd0);
        bus.i_valid = 4'b0000;
        tick();
        chk_out("final.drain", 1'b0, 8'h11, 2'd0);
        $display("[TB] final: o_valid=%0b o_data=%h", bus.o_valid, bus.o_data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
